uart_tx_buffered: RTL and testbench

Parametrised successor to the single-byte UART transmitter. Memory-mapped stores to the UART address push characters into an internal FIFO. A baud-rate FSM drains the FIFO and serialises each character as an 8N1-style frame with configurable data/stop bits. Sits in the Memory Access stage of the CPU top. Exports FIFO status so software can poll it instead of losing bytes while a frame is in flight.

---
 rtl/uart_tx_buffered_pkg.sv | 20 ++
 rtl/uart_tx_buffered_fifo.sv | 53 +++++
 rtl/uart_tx_buffered.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_buffered_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // Bit period in clock cycles, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO holding characters queued for transmission.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO of characters drained by a baud-rate FSM.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rstn_i,
  input  logic                          uart_wr_i,
  input  logic [DATA_BITS-1:0]          uart_dat_i,
  input  logic                          clr_ovf_i,
  output logic                          uart_tx,
  output logic                          fifo_full_o,
  output logic                          fifo_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          tx_busy_o,
  output logic                          ovf_o
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(DIV - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [3:0]           idx, idx_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 tx_q, tx_nx;
  logic                 ovf_q;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic                 full, empty;

  uart_tx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk_i),
    .rst_n (sys_rstn_i),
    .push  (uart_wr_i),
    .pop   (pop),
    .din   (uart_dat_i),
    .dout  (head),
    .count (fifo_count_o),
    .full  (full),
    .empty (empty)
  );

`ifdef UART_TX_PARITY_EN
  logic par, par_nx;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  // The line register follows the current state, so the serial output
  // trails every state change by one cycle while each bit still lasts DIV.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift_nx = shift;
    tx_nx    = 1'b1;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nx   = par;
`endif
    case (state)
      ST_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      ST_START: begin
        tx_nx = 1'b0;
        if (cnt == '0) begin
          cnt_nx   = RELOAD;
          state_nx = ST_DATA;
        end else cnt_nx = cnt - CNT_W'(1);
      end
      ST_DATA: begin
        tx_nx = shift[0];
        if (cnt == '0) begin
          cnt_nx   = RELOAD;
          shift_nx = shift >> 1;
          if (idx == LAST_DATA) begin
            idx_nx = '0;
`ifdef UART_TX_PARITY_EN
            state_nx = ST_PARITY;
`else
            state_nx = ST_STOP;
`endif
          end else idx_nx = idx + 4'd1;
        end else cnt_nx = cnt - CNT_W'(1);
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_nx = par;
        if (cnt == '0) begin
          cnt_nx   = RELOAD;
          state_nx = ST_STOP;
        end else cnt_nx = cnt - CNT_W'(1);
      end
`endif
      ST_STOP: begin
        tx_nx = 1'b1;
        if (cnt == '0) begin
          if (idx == LAST_STOP) begin
            idx_nx = '0;
            if (!empty) pop = 1'b1;
            else begin
              cnt_nx   = '0;
              state_nx = ST_IDLE;
            end
          end else begin
            idx_nx = idx + 4'd1;
            cnt_nx = RELOAD;
          end
        end else cnt_nx = cnt - CNT_W'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
    if (pop) begin
      shift_nx = head;
      cnt_nx   = RELOAD;
      idx_nx   = '0;
      state_nx = ST_START;
`ifdef UART_TX_PARITY_EN
      par_nx   = (^head) ^ (PARITY_ODD != 0);
`endif
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx_q  <= 1'b1;
      ovf_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shift <= shift_nx;
      tx_q  <= tx_nx;
`ifdef UART_TX_PARITY_EN
      par   <= par_nx;
`endif
      if (uart_wr_i && full) ovf_q <= 1'b1;
      else if (clr_ovf_i)    ovf_q <= 1'b0;
    end
  end

  assign uart_tx      = tx_q;
  assign fifo_full_o  = full;
  assign fifo_empty_o = empty;
  assign tx_busy_o    = (state != ST_IDLE) | ~empty;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: scoreboard of queued characters
// checked against the decoded serial line of two differently configured instances.
module tb_uart_tx_buffered;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME1 = (1 + 8 + PB + 1) * DIV;
  localparam int FRAME2 = (1 + 7 + PB + 2) * DIV;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       wr1, clr1, tx1, full1, empty1, busy1, ovf1;
  logic [7:0] dat1;
  logic [2:0] count1;
  logic       wr2, clr2, tx2, full2, empty2, busy2, ovf2;
  logic [6:0] dat2;
  logic [2:0] count2;

  uart_tx_buffered #(
    .CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .STOP_BITS(1),
    .FIFO_DEPTH(4), .PARITY_ODD(0)
  ) u_dut1 (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .uart_wr_i(wr1), .uart_dat_i(dat1),
    .clr_ovf_i(clr1), .uart_tx(tx1), .fifo_full_o(full1), .fifo_empty_o(empty1),
    .fifo_count_o(count1), .tx_busy_o(busy1), .ovf_o(ovf1)
  );

  uart_tx_buffered #(
    .CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .STOP_BITS(2),
    .FIFO_DEPTH(4), .PARITY_ODD(1)
  ) u_dut2 (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .uart_wr_i(wr2), .uart_dat_i(dat2),
    .clr_ovf_i(clr2), .uart_tx(tx2), .fifo_full_o(full2), .fifo_empty_o(empty2),
    .fifo_count_o(count2), .tx_busy_o(busy2), .ovf_o(ovf2)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_on = 1'b1;
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  int starts1[$];
  int starts2[$];
  logic prev1, prev2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge showing the first start-bit cycle; checks every cycle of every bit.
  task automatic run_frame(input bit sel, input logic [8:0] d, input int dbits,
                           input int sbits, input bit odd);
    logic bits [16];
    int   nb;
    int   good;
    logic v;
    logic p;
    bits[0] = 1'b0;
    nb = 1;
    p = odd;
    for (int i = 0; i < dbits; i++) begin
      bits[nb] = d[i];
      p = p ^ d[i];
      nb++;
    end
`ifdef UART_TX_PARITY_EN
    bits[nb] = p;
    nb++;
`endif
    for (int i = 0; i < sbits; i++) begin
      bits[nb] = 1'b1;
      nb++;
    end
    for (int k = 0; k < nb; k++) begin
      good = 0;
      for (int c = 0; c < DIV; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        v = sel ? tx2 : tx1;
        if (v === bits[k]) good++;
      end
      chk($sformatf("frame%0d_d%0h_bit%0d_cycles", sel ? 2 : 1, d, k), good, DIV);
    end
  endtask

  initial begin
    logic [8:0] d;
    prev1 = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on && prev1 === 1'b1 && tx1 === 1'b0) begin
        starts1.push_back(cyc);
        chk("frame1_expected", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          d = q1.pop_front();
          run_frame(1'b0, d, 8, 1, 1'b0);
        end
      end
      prev1 = tx1;
    end
  end

  initial begin
    logic [8:0] d;
    prev2 = 1'b0;
    forever begin
      @(negedge clk);
      if (prev2 === 1'b1 && tx2 === 1'b0) begin
        starts2.push_back(cyc);
        chk("frame2_expected", q2.size() != 0, 1);
        if (q2.size() != 0) begin
          d = q2.pop_front();
          run_frame(1'b1, d, 7, 2, 1'b1);
        end
      end
      prev2 = tx2;
    end
  end

  task automatic write1(input logic [7:0] d, input bit keep);
    wr1 = 1'b1;
    dat1 = d;
    if (keep) q1.push_back({1'b0, d});
    @(negedge clk);
    wr1 = 1'b0;
  endtask

  task automatic write2(input logic [6:0] d);
    wr2 = 1'b1;
    dat2 = d;
    q2.push_back({2'b00, d});
    @(negedge clk);
    wr2 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0 || busy1 || busy2) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int hi;
    rst_n = 1'b0;
    wr1 = 1'b0; dat1 = '0; clr1 = 1'b0;
    wr2 = 1'b0; dat2 = '0; clr2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx1, 1);
    chk("rst_empty", empty1, 1);
    chk("rst_full", full1, 0);
    chk("rst_count", count1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_tx2", tx2, 1);
    chk("rst_state2", {ovf2, full2, busy2, empty2, count2}, 7'b0001000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte with latency check
    starts1.delete();
    write1(8'h55, 1'b1);
    chk("lat_count_n", count1, 1);
    chk("lat_tx_n", tx1, 1);
    @(negedge clk);
    chk("lat_count_n1", count1, 0);
    chk("lat_busy_n1", busy1, 1);
    chk("lat_tx_n1", tx1, 1);
    @(negedge clk);
    chk("lat_tx_n2", tx1, 0);
    drain(400);
    chk("single_busy_end", busy1, 0);
    chk("single_empty_end", empty1, 1);
    chk("single_frames", starts1.size(), 1);

    // Back-to-back frames
    starts1.delete();
    write1(8'h41, 1'b1);
    write1(8'h42, 1'b1);
    chk("b2b_count_a", count1, 1);
    repeat (50) @(negedge clk);
    chk("b2b_count_b", count1, 1);
    repeat (100) @(negedge clk);
    chk("b2b_count_c", count1, 0);
    drain(400);
    chk("b2b_count_d", count1, 0);
    chk("b2b_frames", starts1.size(), 2);
    if (starts1.size() == 2) chk("b2b_gap", starts1[1] - starts1[0], FRAME1);

    // Overflow: sixth write dropped; clear in the same cycle loses to set
    starts1.delete();
    for (int i = 1; i <= 5; i++) write1(8'(i), 1'b1);
    clr1 = 1'b1;
    write1(8'h06, 1'b0);
    clr1 = 1'b0;
    chk("ovf_set_wins", ovf1, 1);
    chk("ovf_full", full1, 1);
    chk("ovf_count", count1, 4);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("ovf_cleared", ovf1, 0);
    drain(800);
    chk("ovf_frames", starts1.size(), 5);

    // 7 data bits, 2 stop bits, odd parity when enabled
    starts2.delete();
    write2(7'h7F);
    write2(7'h03);
    drain(600);
    chk("s2_frames", starts2.size(), 2);
    if (starts2.size() == 2) chk("s2_gap", starts2[1] - starts2[0], FRAME2);

    // Reset during data bit 3 of 0xA5
    mon_on = 1'b0;
    write1(8'hA5, 1'b0);
    repeat (45) @(posedge clk);
    #2;
    chk("rst_mid_pre_tx", tx1, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx1, 1);
    chk("rst_mid_empty", empty1, 1);
    chk("rst_mid_busy", busy1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx1 === 1'b1) hi++;
    end
    chk("rst_line_idle", hi, 30);
    chk("rst_after_busy", busy1, 0);
    mon_on = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
